// File: rtl/countdown_timer_if.sv
// Handshake/status bundle for countdown_timer: the controller side drives start/load/pause/abort,
// the timer side returns count/busy/done.
interface countdown_timer_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output start, load_val, pause, abort,
    input  count, busy, done
  );

  modport slave (
    input  start, load_val, pause, abort,
    output count, busy, done
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with a one-cycle done pulse at terminal count.
// Optional COUNTDOWN_TIMER_AUTO_RELOAD_EN: reload the latched period at terminal count and keep running.
//
// state    | meaning
// ST_IDLE  | waiting for start; count held (0 after any run ends)
// ST_RUN   | counting down once per unpaused cycle; busy high
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input logic             clk,
  input logic             rst,
  countdown_timer_if.slave tif
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] period_q, period_d;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    period_d = period_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tif.start) begin
          if (tif.load_val != CNT_ZERO) begin
            state_d = ST_RUN;
            count_d = tif.load_val;
            busy_d  = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
            period_d = tif.load_val;
`endif
          end else begin
            count_d = CNT_ZERO;
            done_d  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (tif.abort) begin
          state_d = ST_IDLE;
          count_d = CNT_ZERO;
          busy_d  = 1'b0;
        end else if (!tif.pause) begin
          if (count_q > CNT_ONE) begin
            count_d = count_q - CNT_ONE;
          end else begin
            // terminal count; count_q==0 cannot occur in RUN but is treated the same
            done_d = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
            count_d = period_q;
`else
            state_d = ST_IDLE;
            count_d = CNT_ZERO;
            busy_d  = 1'b0;
`endif
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = CNT_ZERO;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= CNT_ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      period_q <= CNT_ZERO;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      period_q <= period_d;
`endif
    end
  end

  assign tif.count = count_q;
  assign tif.busy  = busy_q;
  assign tif.done  = done_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: vector table, corner-case sequences and a random run
// against a cycle-accounting reference model.
module tb_countdown_timer;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk;
  logic rst;
  int errors;
  int checks;

  countdown_timer_if #(.WIDTH(4)) tif ();
  countdown_timer #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .tif(tif.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       rst;
    bit       start;
    bit [3:0] ld;
    bit       pause;
    bit       abort;
    int       exp_count;
    bit       exp_busy;
    bit       exp_done;
  } vec_t;

  vec_t vecs[19];

  // reference model: a run is "load minus unpaused cycles elapsed since start"
  bit m_run;
  bit m_done;
  int m_load;
  int m_elapsed;

  function automatic vec_t mk(bit r, bit s, int ld, bit p, bit a, int ec, bit eb, bit ed);
    vec_t v;
    v.rst = r; v.start = s; v.ld = 4'(ld); v.pause = p; v.abort = a;
    v.exp_count = ec; v.exp_busy = eb; v.exp_done = ed;
    return v;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic check_all(input string tag, input int ec, input bit eb, input bit ed);
    check({tag, "_count"}, int'(tif.count), ec);
    check({tag, "_busy"}, int'(tif.busy), int'(eb));
    check({tag, "_done"}, int'(tif.done), int'(ed));
  endtask

  task automatic drive(input bit r, input bit s, input int ld, input bit p, input bit a);
    rst = r;
    tif.start = s;
    tif.load_val = 4'(ld);
    tif.pause = p;
    tif.abort = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input bit r, input bit s, input int ld, input bit p, input bit a);
    if (r) begin
      m_run = 0; m_done = 0; m_elapsed = 0;
    end else begin
      m_done = 0;
      if (!m_run) begin
        if (s) begin
          if (ld == 0) m_done = 1;
          else begin
            m_run = 1; m_load = ld; m_elapsed = 0;
          end
        end
      end else if (a) begin
        m_run = 0;
      end else if (!p) begin
        m_elapsed++;
        if (m_elapsed == m_load) begin
          m_done = 1;
          if (AR) m_elapsed = 0;
          else m_run = 0;
        end
      end
    end
  endtask

  initial begin
    int done_seen;
    errors = 0;
    checks = 0;
    drive(1, 0, 0, 0, 0);

    vecs[0]  = mk(1, 0, 0,  0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 7,  0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0,  1, 1, 0, 0, 0);
    vecs[3]  = mk(0, 1, 0,  0, 0, 0, 0, 1);
    vecs[4]  = mk(0, 1, 2,  0, 0, 2, 1, 0);
    vecs[5]  = mk(0, 1, 9,  0, 0, 1, 1, 0);
    vecs[6]  = mk(0, 0, 0,  0, 0, AR ? 2 : 0, AR, 1);
    vecs[7]  = mk(0, 0, 0,  0, 1, 0, 0, 0);
    vecs[8]  = mk(0, 1, 6,  0, 0, 6, 1, 0);
    vecs[9]  = mk(0, 0, 0,  0, 0, 5, 1, 0);
    vecs[10] = mk(0, 0, 0,  0, 0, 4, 1, 0);
    vecs[11] = mk(0, 0, 0,  0, 0, 3, 1, 0);
    vecs[12] = mk(0, 0, 0,  0, 0, 2, 1, 0);
    vecs[13] = mk(0, 0, 0,  0, 0, 1, 1, 0);
    vecs[14] = mk(0, 0, 0,  1, 1, 0, 0, 0);
    vecs[15] = mk(0, 0, 0,  0, 0, 0, 0, 0);
    vecs[16] = mk(0, 1, 15, 0, 0, 15, 1, 0);
    vecs[17] = mk(0, 0, 0,  1, 0, 15, 1, 0);
    vecs[18] = mk(0, 0, 0,  0, 1, 0, 0, 0);

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].rst, vecs[i].start, int'(vecs[i].ld), vecs[i].pause, vecs[i].abort);
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_busy, vecs[i].exp_done);
    end

    // basic run of 10
    drive(0, 1, 10, 0, 0);
    tick();
    check_all("basic_load", 10, 1, 0);
    drive(0, 0, 0, 0, 0);
    for (int k = 9; k >= 1; k--) begin
      tick();
      check_all($sformatf("basic_c%0d", k), k, 1, 0);
    end
    tick();
    check_all("basic_term", AR ? 10 : 0, AR, 1);
    drive(0, 0, 0, 0, 1);
    tick();
    check_all("basic_abort", 0, 0, 0);

    // pause for 3 cycles while count is 3
    drive(0, 1, 5, 0, 0);
    tick();
    check_all("pause_load", 5, 1, 0);
    drive(0, 0, 0, 0, 0);
    tick(); check_all("pause_c4", 4, 1, 0);
    tick(); check_all("pause_c3", 3, 1, 0);
    drive(0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_all($sformatf("pause_hold%0d", k), 3, 1, 0);
    end
    drive(0, 0, 0, 0, 0);
    tick(); check_all("pause_c2", 2, 1, 0);
    tick(); check_all("pause_c1", 1, 1, 0);
    tick(); check_all("pause_term", AR ? 5 : 0, AR, 1);
    drive(0, 0, 0, 0, 1);
    tick();
    check_all("pause_abort", 0, 0, 0);

    // reset mid-count
    drive(0, 1, 9, 0, 0);
    tick();
    check_all("rstmid_load", 9, 1, 0);
    drive(0, 0, 0, 0, 0);
    for (int k = 8; k >= 5; k--) begin
      tick();
      check_all($sformatf("rstmid_c%0d", k), k, 1, 0);
    end
    drive(1, 0, 0, 0, 0);
    tick();
    check_all("rstmid_rst", 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (tif.done) done_seen++;
    end
    check("rstmid_no_done", done_seen, 0);

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    // periodic done with start held high (ignored in RUN)
    drive(0, 1, 3, 0, 0);
    tick();
    check_all("ar_load", 3, 1, 0);
    drive(0, 1, 7, 0, 0);
    for (int p = 0; p < 4; p++) begin
      tick(); check_all($sformatf("ar_p%0d_c2", p), 2, 1, 0);
      tick(); check_all($sformatf("ar_p%0d_c1", p), 1, 1, 0);
      tick(); check_all($sformatf("ar_p%0d_term", p), 3, 1, 1);
    end
    drive(0, 0, 0, 0, 1);
    tick();
    check_all("ar_abort", 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    done_seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (tif.done) done_seen++;
    end
    check("ar_stopped", done_seen, 0);
`endif

    // randomized run against the reference model
    drive(1, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0);
    tick();
    for (int n = 0; n < 600; n++) begin
      bit r, s, p, a;
      int ld;
      r  = ($urandom_range(0, 99) < 2);
      s  = ($urandom_range(0, 2) == 0);
      ld = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4));
      p  = ($urandom_range(0, 4) == 0);
      a  = ($urandom_range(0, 14) == 0);
      drive(r, s, ld, p, a);
      model_step(r, s, ld, p, a);
      tick();
      check_all($sformatf("rand%0d", n), m_run ? (m_load - m_elapsed) : 0, m_run, m_done);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter: loads a start value, decrements once per `clk` until it reaches zero, then emits a one-cycle `done` pulse.
- It is the down-counting mirror of the bench-side up-counting loops. Benches and control FSMs use it to wait a programmable number of cycles.
- Fixed-width arithmetic with explicit terminal-count detection. No reliance on wrap-around.

Parameters:
- WIDTH, 4, counter and load value width in bits (max load 2**WIDTH-1).

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- start  input  1  request to load `load_val` and begin counting (sampled in IDLE only)
- load_val  input  WIDTH  initial count, sampled on the cycle `start` is accepted
- pause  input  1  while high in RUN, `count` holds
- abort  input  1  while high in RUN, return to IDLE with no `done`
- count  output  WIDTH  current remaining count (registered)
- busy  output  1  high while in RUN (registered)
- done  output  1  one-cycle pulse on terminal count (registered)

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: when `rst` is high at a posedge, the next state is IDLE and `count`=0, `busy`=0, `done`=0. This overrides every other input, including mid-count.
- Two states: IDLE and RUN. `done` is a registered pulse and defaults to 0 every cycle unless set as below.
- IDLE, `start`=1, `load_val`>0: next state RUN, `count`<=`load_val`, `busy`<=1.
- IDLE, `start`=1, `load_val`=0: stay IDLE, `count`<=0, `done`<=1 for one cycle (zero-length wait).
- IDLE, `start`=0: hold `count`.
- RUN, `abort`=1: next state IDLE, `count`<=0, `busy`<=0, `done` stays 0. `abort` has priority over `pause` and over terminal count.
- RUN, `pause`=1, `abort`=0: hold state and `count`.
- RUN, neither asserted, `count`>1: `count`<=`count`-1.
- RUN, neither asserted, `count`=1: `count`<=0, `done`<=1, `busy`<=0, next state IDLE.
- `start` in RUN is ignored; `load_val` is not re-sampled.
- Latency:
  - `start` accepted at edge N gives `count`=L after edge N.
  - `count` reaches 0 and `done`=1 after edge N+L (with no pause).
  - Each paused cycle adds one cycle.
- `start` may be re-asserted in the same cycle `done` is high (IDLE): accepted, back-to-back runs with no gap cycle.
- `count` never underflows. Decrement happens only when `count`>=1 in RUN.
- `abort` and `pause` are ignored in IDLE.

Optional Feature:
- Macro: COUNTDOWN_TIMER_AUTO_RELOAD_EN.
- Defined:
  - `load_val` accepted at `start` is latched into an internal period register.
  - At terminal count in RUN, `count`<=period, `done`<=1, `busy` stays 1, and the state remains RUN, giving a periodic `done` every `period` cycles.
  - Only `abort` or `rst` returns to IDLE.
  - `start` with `load_val`=0 behaves as in the base design (single `done`, stay IDLE).
- Not defined: no period register; terminal count returns to IDLE as specified above.

Test Plan:
- Reset mid-count: `start`, `load_val`=9, assert `rst` after 4 cycles -> next cycle `count`=0, `busy`=0, `done`=0; no `done` ever follows.
- Basic run: `load_val`=10, `start` one cycle -> `count` 10,9,...,1,0 on consecutive edges; `done`=1 exactly once, in the cycle `count`=0; `busy` low from the same edge.
- Pause: `load_val`=5, `pause` high for 3 cycles while `count`=3 -> `count` holds 3 for 3 cycles; `done` arrives 8 cycles after start.
- Abort priority: `load_val`=6, at `count`=1 assert `abort`+`pause` together -> `count`=0, IDLE, `done` never asserts.
- Zero load and back-to-back: `start` with `load_val`=0 -> `done` next cycle, `busy` stays 0; then re-`start` with `load_val`=2 on the `done` cycle -> `count` 2,1,0 with no idle gap, second `done` 2 cycles later.
- With macro: `load_val`=3 -> `done` pulses every 3 cycles, 4 times; `abort` -> IDLE and pulses stop; `start` ignored throughout RUN.
